serial_shift_controller: RTL

Multi-cycle shift sequencer that implements SLL, SRL and SRA by an arbitrary amount by applying a single-position shift stage once per clock. It sits beside the ALU as a low-area alternative to a barrel shifter. Shift instructions are issued with a start/busy/done handshake, and the pipeline stalls on `busy`. The control FSM owns a working register and an iteration counter, and feeds the register back through the one-bit shift stage.

---
 rtl/shift_ctrl_pkg.sv | 12 +
 rtl/shift_one_step.sv | 15 +
 rtl/serial_shift_controller.sv | 55 +++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared op codes and FSM states for the serial shifter
package shift_ctrl_pkg;
  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/shift_one_step.sv
// shift_one_step: single-position SLL/SRL/SRA stage, PASS forwards the input
module shift_one_step
  import shift_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] X,
  input  logic [1:0]   op,
  output logic [N-1:0] Y
);
  always_comb
    Y = op == OP_SLL ? {X[N-2:0], 1'b0} :
        op == OP_SRL ? {1'b0, X[N-1:1]} :
        op == OP_SRA ? {X[N-1], X[N-1:1]} : X;
endmodule

// File: rtl/serial_shift_controller.sv
// serial_shift_controller: multi-cycle shifter applying one bit position per clock
module serial_shift_controller
  import shift_ctrl_pkg::*;
#(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N-1:0]       operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       result
);
  state_t state, state_n;
  logic [N-1:0] work, step;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0] op_q;
  logic load, direct, last;
  shift_one_step #(.N(N)) u_step (.X(work), .op(op_q), .Y(step));
  // DONE accepts a new request just like IDLE, giving back-to-back issue
  always_comb begin
    load    = start && state != S_SHIFT;
    direct  = shamt == '0 || op == OP_PASS;
    last    = state == S_SHIFT && cnt == SHAMT_W'(1);
    state_n = load ? (direct ? S_DONE : S_SHIFT) :
              state == S_SHIFT ? (last ? S_DONE : S_SHIFT) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      work   <= '0;
      cnt    <= '0;
      op_q   <= OP_SLL;
      result <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        work <= operand;
        cnt  <= shamt;
        op_q <= op;
      end else if (state == S_SHIFT) begin
        work <= step;
        cnt  <= cnt - 1'b1;
      end
      if (load && direct) result <= operand;
      else if (last) result <= step;
    end
  end
  assign busy = state == S_SHIFT;
  assign done = state == S_DONE;
endmodule
